// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Requester-side driver for the 32-bit combinational ALU. Accepts one
// operation at a time, registers the operands and opcode onto the ALU
// inputs, waits a fixed number of clock edges for the ALU path (including
// the multiplier) to settle, captures the result and zero flag, and then
// offers them as a response.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both 1. REQ_READY depends only on the state
// register, never on REQ_VALID. Once RSP_VALID is raised, RSP_DATA,
// RSP_ZERO and RSP_ERR hold steady until the edge where RSP_READY=1 is seen.
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-low reset
//   REQ_VALID/READY   request handshake
//   REQ_OP1/OP2/OPRN  request operands and opcode
//   ALU_OP1/OP2/OPRN  registered drive to the ALU (ALU_OPRN is 0 when idle)
//   ALU_OUT/ALU_ZERO  ALU result and zero flag
//   RSP_VALID/READY   response handshake
//   RSP_DATA/ZERO/ERR captured result, zero flag, undefined-opcode flag
//   BUSY              high whenever the FSM is not idle
//   OP_COUNT          completed response handshakes, wraps
module alu_op_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPRN_WIDTH    = 6,
  parameter int SETTLE_CYCLES = 2,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   REQ_VALID,
  output logic                   REQ_READY,
  input  logic [DATA_WIDTH-1:0]  REQ_OP1,
  input  logic [DATA_WIDTH-1:0]  REQ_OP2,
  input  logic [OPRN_WIDTH-1:0]  REQ_OPRN,
  output logic [DATA_WIDTH-1:0]  ALU_OP1,
  output logic [DATA_WIDTH-1:0]  ALU_OP2,
  output logic [OPRN_WIDTH-1:0]  ALU_OPRN,
  input  logic [DATA_WIDTH-1:0]  ALU_OUT,
  input  logic                   ALU_ZERO,
  output logic                   RSP_VALID,
  input  logic                   RSP_READY,
  output logic [DATA_WIDTH-1:0]  RSP_DATA,
  output logic                   RSP_ZERO,
  output logic                   RSP_ERR,
  output logic                   BUSY,
  output logic [COUNT_WIDTH-1:0] OP_COUNT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic       oprn_legal;

  // Defined operations are 0x01..0x09; everything else (including any value
  // with upper bits set) is rejected without ever sampling the ALU, whose
  // output is high-impedance for undefined opcodes.
  assign oprn_legal = (REQ_OPRN != '0) && (REQ_OPRN <= OPRN_WIDTH'(9));

  assign REQ_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (REQ_VALID) state_d = oprn_legal ? S_SETTLE : S_RESP;
      S_SETTLE: if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP:   if (RSP_READY) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      ALU_OP1   <= '0;
      ALU_OP2   <= '0;
      ALU_OPRN  <= '0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_ZERO  <= 1'b0;
      RSP_ERR   <= 1'b0;
      OP_COUNT  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (REQ_VALID) begin
            if (oprn_legal) begin
              ALU_OP1  <= REQ_OP1;
              ALU_OP2  <= REQ_OP2;
              ALU_OPRN <= REQ_OPRN;
              // Counts down to zero; the capture happens on the edge that
              // sees zero, giving SETTLE_CYCLES edges after the accept.
              cnt_q    <= 4'(SETTLE_CYCLES - 1);
            end else begin
              RSP_DATA  <= '0;
              RSP_ZERO  <= 1'b0;
              RSP_ERR   <= 1'b1;
              RSP_VALID <= 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            RSP_DATA  <= ALU_OUT;
            RSP_ZERO  <= ALU_ZERO;
            RSP_ERR   <= 1'b0;
            RSP_VALID <= 1'b1;
          end
        end
        S_RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            OP_COUNT  <= OP_COUNT + COUNT_WIDTH'(1);
            ALU_OPRN  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer. Two instances share request fields,
// RSP_READY and reset: dut_a uses the default parameters, dut_b uses
// SETTLE_CYCLES=4 and COUNT_WIDTH=4. Each has its own REQ_VALID and its own
// behavioural ALU model.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [5:0]  req_oprn;
  logic        rsp_ready;

  logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_zero_a, rsp_err_a, busy_a;
  logic [31:0] alu_op1_a, alu_op2_a, alu_out_a, rsp_data_a;
  logic [5:0]  alu_oprn_a;
  logic        alu_zero_a;
  logic [15:0] op_count_a;

  logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_zero_b, rsp_err_b, busy_b;
  logic [31:0] alu_op1_b, alu_op2_b, alu_out_b, rsp_data_b;
  logic [5:0]  alu_oprn_b;
  logic        alu_zero_b;
  logic [3:0]  op_count_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_cnt_a;
  logic [31:0] exp_cnt_b;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU model ----------------
  // Undefined opcodes return a garbage pattern standing in for the
  // high-impedance output, so any sampling of it shows up in RSP_DATA.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h01:   alu_f = a + b;
      6'h02:   alu_f = a - b;
      6'h03:   alu_f = a * b;
      6'h04:   alu_f = a >> b;
      6'h05:   alu_f = a << b;
      6'h06:   alu_f = a & b;
      6'h07:   alu_f = a | b;
      6'h08:   alu_f = ~(a | b);
      6'h09:   alu_f = {31'd0, (a < b)};
      default: alu_f = 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out_a  = alu_f(alu_op1_a, alu_op2_a, alu_oprn_a);
  assign alu_zero_a = (alu_out_a == 32'd0);
  assign alu_out_b  = alu_f(alu_op1_b, alu_op2_b, alu_oprn_b);
  assign alu_zero_b = (alu_out_b == 32'd0);

  alu_op_sequencer dut_a (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid_a), .REQ_READY(req_ready_a),
    .REQ_OP1(req_op1), .REQ_OP2(req_op2), .REQ_OPRN(req_oprn),
    .ALU_OP1(alu_op1_a), .ALU_OP2(alu_op2_a), .ALU_OPRN(alu_oprn_a),
    .ALU_OUT(alu_out_a), .ALU_ZERO(alu_zero_a),
    .RSP_VALID(rsp_valid_a), .RSP_READY(rsp_ready),
    .RSP_DATA(rsp_data_a), .RSP_ZERO(rsp_zero_a), .RSP_ERR(rsp_err_a),
    .BUSY(busy_a), .OP_COUNT(op_count_a)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(4), .COUNT_WIDTH(4)) dut_b (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid_b), .REQ_READY(req_ready_b),
    .REQ_OP1(req_op1), .REQ_OP2(req_op2), .REQ_OPRN(req_oprn),
    .ALU_OP1(alu_op1_b), .ALU_OP2(alu_op2_b), .ALU_OPRN(alu_oprn_b),
    .ALU_OUT(alu_out_b), .ALU_ZERO(alu_zero_b),
    .RSP_VALID(rsp_valid_b), .RSP_READY(rsp_ready),
    .RSP_DATA(rsp_data_b), .RSP_ZERO(rsp_zero_b), .RSP_ERR(rsp_err_b),
    .BUSY(busy_b), .OP_COUNT(op_count_b)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // One complete operation on dut_a (sel=0) or dut_b (sel=1) with RSP_READY
  // held high. exp_lat is the number of edges after the accept edge before
  // RSP_VALID is seen.
  task automatic do_op(input bit sel, input string tag,
                       input logic [31:0] op1, input logic [31:0] op2, input logic [5:0] oprn,
                       input logic [31:0] exp_data, input logic exp_zero, input logic exp_err,
                       input int exp_lat, input logic [31:0] exp_cnt);
    int lat;
    req_op1   = op1;
    req_op2   = op2;
    req_oprn  = oprn;
    rsp_ready = 1'b1;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    check({tag, " alu_oprn"}, sel ? 32'(alu_oprn_b) : 32'(alu_oprn_a),
          exp_err ? 32'd0 : 32'(oprn));
    lat = 0;
    while (!(sel ? rsp_valid_b : rsp_valid_a) && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " data"}, sel ? rsp_data_b : rsp_data_a, exp_data);
    check({tag, " zero"}, sel ? 32'(rsp_zero_b) : 32'(rsp_zero_a), 32'(exp_zero));
    check({tag, " err"}, sel ? 32'(rsp_err_b) : 32'(rsp_err_a), 32'(exp_err));
    tick();
    check({tag, " valid_low"}, sel ? 32'(rsp_valid_b) : 32'(rsp_valid_a), 32'd0);
    check({tag, " count"}, sel ? 32'(op_count_b) : 32'(op_count_a), exp_cnt);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_op1 = '0;
    req_op2 = '0;
    req_oprn = '0;
    rsp_ready = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    repeat (3) tick();
    rst = 1'b1;

    // Reset state
    check("rst req_ready_a", 32'(req_ready_a), 32'd1);
    check("rst rsp_valid_a", 32'(rsp_valid_a), 32'd0);
    check("rst busy_a", 32'(busy_a), 32'd0);
    check("rst count_a", 32'(op_count_a), 32'd0);
    check("rst alu_oprn_a", 32'(alu_oprn_a), 32'd0);
    check("rst alu_op1_a", alu_op1_a, 32'd0);
    check("rst rsp_data_a", rsp_data_a, 32'd0);
    check("rst req_ready_b", 32'(req_ready_b), 32'd1);
    check("rst count_b", 32'(op_count_b), 32'd0);

    // Test 1: add 5 + 3, step by step
    req_op1 = 32'h5; req_op2 = 32'h3; req_oprn = 6'h01; rsp_ready = 1'b1;
    req_valid_a = 1'b1;
    tick();  // E0
    req_valid_a = 1'b0;
    check("t1 alu_oprn", 32'(alu_oprn_a), 32'h01);
    check("t1 busy", 32'(busy_a), 32'd1);
    check("t1 req_ready", 32'(req_ready_a), 32'd0);
    check("t1 valid_e0", 32'(rsp_valid_a), 32'd0);
    tick();  // E1
    check("t1 valid_e1", 32'(rsp_valid_a), 32'd0);
    tick();  // E2
    check("t1 valid_e2", 32'(rsp_valid_a), 32'd1);
    check("t1 data", rsp_data_a, 32'h8);
    check("t1 zero", 32'(rsp_zero_a), 32'd0);
    check("t1 err", 32'(rsp_err_a), 32'd0);
    tick();  // handshake
    exp_cnt_a = 1;
    check("t1 valid_after", 32'(rsp_valid_a), 32'd0);
    check("t1 count", 32'(op_count_a), exp_cnt_a);
    check("t1 alu_oprn_idle", 32'(alu_oprn_a), 32'd0);
    check("t1 data_retained", rsp_data_a, 32'h8);
    check("t1 req_ready_back", 32'(req_ready_a), 32'd1);

    // Test 2: subtraction to zero
    exp_cnt_a++;
    do_op(1'b0, "t2 sub", 32'h1234_5678, 32'h1234_5678, 6'h02, 32'd0, 1'b1, 1'b0, 2, exp_cnt_a);

    // Test 3: illegal opcodes, plus legal boundary 0x09 and illegal 0x00/0x0A
    exp_cnt_a++;
    do_op(1'b0, "t3 ill0c", 32'hFFFF_0000, 32'h1, 6'h0C, 32'd0, 1'b0, 1'b1, 0, exp_cnt_a);
    check("t3 alu_op1_unchanged", alu_op1_a, 32'h1234_5678);
    exp_cnt_a++;
    do_op(1'b0, "t3 ill21", 32'h7, 32'h7, 6'h21, 32'd0, 1'b0, 1'b1, 0, exp_cnt_a);
    exp_cnt_a++;
    do_op(1'b0, "t3 ill00", 32'h7, 32'h7, 6'h00, 32'd0, 1'b0, 1'b1, 0, exp_cnt_a);
    exp_cnt_a++;
    do_op(1'b0, "t3 ill0a", 32'h7, 32'h7, 6'h0A, 32'd0, 1'b0, 1'b1, 0, exp_cnt_a);
    exp_cnt_a++;
    do_op(1'b0, "t3 slt09", 32'h5, 32'h7, 6'h09, 32'd1, 1'b0, 1'b0, 2, exp_cnt_a);
    exp_cnt_a++;
    do_op(1'b0, "t3 nor08", 32'hF0F0_0000, 32'h0000_0F0F, 6'h08, 32'h0F0F_F0F0, 1'b0, 1'b0, 2,
          exp_cnt_a);

    // Test 4: multiply with backpressure; a request pulse mid-stall is ignored
    req_op1 = 32'h0001_0000; req_op2 = 32'h0001_0000; req_oprn = 6'h03; rsp_ready = 1'b0;
    req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    tick();
    tick();
    check("t4 valid", 32'(rsp_valid_a), 32'd1);
    for (int i = 0; i < 10; i++) begin
      req_valid_a = (i == 5);
      req_oprn    = (i == 5) ? 6'h01 : 6'h03;
      tick();
      check("t4 hold_valid", 32'(rsp_valid_a), 32'd1);
      check("t4 hold_data", rsp_data_a, 32'd0);
      check("t4 hold_zero", 32'(rsp_zero_a), 32'd1);
      check("t4 req_ready", 32'(req_ready_a), 32'd0);
    end
    req_valid_a = 1'b0;
    rsp_ready = 1'b1;
    tick();
    exp_cnt_a++;
    check("t4 valid_low", 32'(rsp_valid_a), 32'd0);
    check("t4 count", 32'(op_count_a), exp_cnt_a);
    tick();
    check("t4 idle_busy", 32'(busy_a), 32'd0);
    check("t4 idle_oprn", 32'(alu_oprn_a), 32'd0);

    // Test 5: reset during SETTLE
    req_op1 = 32'h1; req_op2 = 32'h2; req_oprn = 6'h01;
    req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    check("t5 busy_before", 32'(busy_a), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    check("t5 valid", 32'(rsp_valid_a), 32'd0);
    check("t5 busy", 32'(busy_a), 32'd0);
    check("t5 req_ready", 32'(req_ready_a), 32'd1);
    check("t5 count", 32'(op_count_a), exp_cnt_a);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5 no_rsp", 32'(rsp_valid_a), 32'd0);
    end

    // Test 6: dut_b counter wrap over 17 ops, every third op illegal
    for (int i = 1; i <= 17; i++) begin
      exp_cnt_b = 32'(i) & 32'hF;
      if (i % 3 == 0)
        do_op(1'b1, "t6 ill", 32'(i), 32'h1, 6'h3F, 32'd0, 1'b0, 1'b1, 0, exp_cnt_b);
      else
        do_op(1'b1, "t6 add", 32'(i), 32'h1, 6'h01, 32'(i) + 32'd1, 1'b0, 1'b0, 4, exp_cnt_b);
    end

    // Test 2 repeated with SETTLE_CYCLES=4
    exp_cnt_b = (exp_cnt_b + 1) & 32'hF;
    do_op(1'b1, "t2b sub", 32'h1234_5678, 32'h1234_5678, 6'h02, 32'd0, 1'b1, 1'b0, 4, exp_cnt_b);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Requester-side driver for the 32-bit combinational ALU: accepts one operation request at a time over a valid/ready handshake.
- Registers OP1/OP2/OPRN onto the ALU inputs and waits a fixed settle time for the ALU path, which includes the multiplier.
- Captures the ALU result and zero flag, then presents them over a valid/ready response handshake.
- Sits between the control unit and the ALU. Rejects undefined opcodes without sampling the ALU, whose undefined-op output is high-impedance.

Parameters:
- DATA_WIDTH, 32, operand/result width
- OPRN_WIDTH, 6, opcode width
- SETTLE_CYCLES, 2, clock edges between driving the ALU and capturing its result (legal range 1..15)
- COUNT_WIDTH, 16, width of the completed-operation counter

Ports:
- CLK  input  1  clock; all logic on the rising edge
- RST  input  1  synchronous, active-low reset
- REQ_VALID  input  1  request valid
- REQ_READY  output  1  sequencer can accept a request
- REQ_OP1  input  DATA_WIDTH  operand 1
- REQ_OP2  input  DATA_WIDTH  operand 2
- REQ_OPRN  input  OPRN_WIDTH  operation code
- ALU_OP1  output  DATA_WIDTH  registered operand 1 to ALU
- ALU_OP2  output  DATA_WIDTH  registered operand 2 to ALU
- ALU_OPRN  output  OPRN_WIDTH  registered opcode to ALU
- ALU_OUT  input  DATA_WIDTH  ALU result
- ALU_ZERO  input  1  ALU zero flag
- RSP_VALID  output  1  response valid
- RSP_READY  input  1  consumer accepts response
- RSP_DATA  output  DATA_WIDTH  captured result
- RSP_ZERO  output  1  captured zero flag
- RSP_ERR  output  1  request had an undefined opcode
- BUSY  output  1  state != IDLE
- OP_COUNT  output  COUNT_WIDTH  count of completed response handshakes

Behaviour:
- Reset (RST=0 at a rising edge):
  - state=IDLE, settle counter=0.
  - All outputs 0, except REQ_READY=1 after reset.
  - Reset mid-operation aborts it: no response is produced and OP_COUNT is cleared.
- Legal opcodes: 0x01..0x09. Everything else is illegal, including 0x00, 0x0A..0x0F and any value with OPRN[5:4] != 0.
- States:
  - IDLE, SETTLE, RESP. REQ_READY = (state==IDLE), registered-equivalent with no combinational path from REQ_VALID.
- IDLE:
  - On an edge with REQ_VALID=1, the request is accepted (accept edge E0).
  - Legal opcode: ALU_OP1/OP2/OPRN <= request fields; counter <= SETTLE_CYCLES-1; go to SETTLE.
  - Illegal opcode: ALU_* unchanged; RSP_DATA <= 0, RSP_ZERO <= 0, RSP_ERR <= 1, RSP_VALID <= 1; go to RESP. RSP_VALID is high after E0.
- SETTLE:
  - Counter nonzero: decrement.
  - Counter zero: RSP_DATA <= ALU_OUT, RSP_ZERO <= ALU_ZERO, RSP_ERR <= 0, RSP_VALID <= 1; go to RESP.
  - Net latency: RSP_VALID high after edge E(SETTLE_CYCLES). Inputs on REQ_* are ignored during SETTLE.
- RESP:
  - RSP_* held stable while RSP_VALID=1 and RSP_READY=0, for unbounded backpressure.
  - On an edge with RSP_READY=1: RSP_VALID <= 0, OP_COUNT <= OP_COUNT+1 (wraps modulo 2^COUNT_WIDTH, no saturation), ALU_OPRN <= 0, go to IDLE.
  - RSP_DATA/ZERO/ERR retain their last values after the handshake.
- ALU_OP1/ALU_OP2 hold their last values in IDLE. ALU_OPRN is 0 in IDLE.
- No request is accepted in the same cycle as a response handshake. Minimum spacing between accepts is SETTLE_CYCLES+2 cycles.
- RSP_ERR responses also increment OP_COUNT.

Test Plan:
1. Reset, then add: REQ OP1=0x0000_0005, OP2=0x0000_0003, OPRN=0x01, RSP_READY=1, bench ALU model -> ALU_OPRN=0x01 after E0; RSP_VALID after E2 with RSP_DATA=0x8, ZERO=0, ERR=0; OP_COUNT=1 after the next edge.
2. Sub giving zero: OP1=OP2=0x1234_5678, OPRN=0x02 -> RSP_DATA=0, RSP_ZERO=1. Repeat with SETTLE_CYCLES=4 -> RSP_VALID first seen after E4.
3. Illegal opcode 0x0C, then 0x21 -> RSP_VALID after E0, ERR=1, DATA=0, ZERO=0; ALU_OPRN stays 0; OP_COUNT increments twice.
4. Backpressure: mul 0x0001_0000*0x0001_0000 (OPRN=0x03), RSP_READY=0 for 10 cycles -> RSP_DATA=0 held stable, REQ_READY=0 throughout; a REQ_VALID pulse during the stall is not accepted; the handshake returns to IDLE.
5. Reset mid-op: drive RST=0 during SETTLE -> next cycle RSP_VALID=0, BUSY=0, REQ_READY=1, OP_COUNT=0; no response appears.
6. Counter wrap: COUNT_WIDTH=4, complete 17 operations -> OP_COUNT reads 0xF after op 15, 0x0 after op 16, 0x1 after op 17.
